pipo_universal_shift_reg: RTL
=============================

PIPO_UNIVERSAL_SHIFT_REG -- requirements
Module: pipo_universal_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, register width in bits, legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port mode, input, 3, operation select sampled at each rising clk.
REQ-005 The block SHALL have port din, input, WIDTH, parallel load data.
REQ-006 The block SHALL have port sin_lsb, input, 1, serial bit entering bit 0 on shift-left.
REQ-007 The block SHALL have port sin_msb, input, 1, serial bit entering bit WIDTH-1 on shift-right.
REQ-008 The block SHALL have port q, output, WIDTH, registered parallel output.
REQ-009 The block SHALL have port sout_msb, output, 1, equal to q[WIDTH-1], combinational from q.
REQ-010 The block SHALL have port sout_lsb, output, 1, equal to q[0], combinational from q.
REQ-011 The block SHALL have port count, output, clog2(WIDTH+1), number of shift/rotate operations since the last load, registered.
REQ-012 The block SHALL have port done, output, 1, registered one-cycle pulse marking completion of WIDTH shifts.

Function
REQ-013 The mode encoding SHALL be: 000 HOLD, 001 SHL, 010 SHR, 011 LOAD, 100 ROL, 101 ROR; 110 and 111 SHALL behave as HOLD.
REQ-014 HOLD SHALL keep q and count unchanged.
REQ-015 SHL SHALL set q to {q[WIDTH-2:0], sin_lsb}.
REQ-016 SHR SHALL set q to {sin_msb, q[WIDTH-1:1]}.
REQ-017 LOAD SHALL set q to din and count to 0, one-cycle latency (q valid after the sampling edge).
REQ-018 ROL SHALL set q to {q[WIDTH-2:0], q[WIDTH-1]}; ROR SHALL set q to {q[0], q[WIDTH-1:1]}; serial inputs ignored.
REQ-019 Each SHL, SHR, ROL or ROR cycle SHALL increment count by 1, saturating at WIDTH (no wrap-around).
REQ-020 done SHALL be 1 for exactly the cycle after the edge on which count moves from WIDTH-1 to WIDTH, otherwise 0.
REQ-021 Further shifts with count saturated at WIDTH SHALL update q but SHALL NOT reassert done.
REQ-022 HOLD or illegal mode SHALL force done to 0 on the next edge.
REQ-023 Mode changes between any two operations on consecutive cycles SHALL take effect with no bubble.

Reset
REQ-024 Asserting rst SHALL immediately, without a clock edge, set q to all zeros, count to 0 and done to 0, including mid-shift sequence.
REQ-025 While rst is high all inputs SHALL be ignored; the first operation executes on the first rising clk after rst deasserts.

Structure
REQ-026 A shared package shift_pkg SHALL hold the mode encoding constants (MODE_HOLD .. MODE_ROR) and the mode typedef, for reuse by testbenches and sibling shift blocks.
REQ-027 The register SHALL be built from WIDTH instances of one sub-module usr_bit_cell (per-bit mode mux plus async-reset flip-flop); count/done logic SHALL sit in the top level.

Verification
REQ-028 WIDTH=4: LOAD din=1011 -> q=1011, count=0, done=0 after one edge.
REQ-029 From q=1011: SHL sin_lsb=0 -> 0110; then SHR sin_msb=1 -> 1011; count=2.
REQ-030 From q=1011: ROR -> 1101, ROL -> 1011; sout_msb/sout_lsb track q[3]/q[0] each cycle.
REQ-031 LOAD 1001 then 4 consecutive SHL -> done high only in the cycle after the 4th edge, count=4; 5th SHL -> count stays 4, done=0.
REQ-032 rst asserted between clock edges after 2 shifts -> q=0000, count=0, done=0 immediately; mode=111 afterwards -> q held.
REQ-033 WIDTH=8: LOAD 0x81 then ROL -> 0x03; 8 shifts -> single done pulse, count=8.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared mode encoding for the universal shift register family.
// Also used by testbenches and sibling shift blocks.
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101
  } mode_t;

  function automatic logic is_shift(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) ||
           (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: mode mux into an
// async-reset flip-flop. Neighbour taps are wired by the parent.
module usr_bit_cell
  import shift_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode,
  input  logic       load_bit,
  input  logic       shl_bit,
  input  logic       shr_bit,
  input  logic       rol_bit,
  input  logic       ror_bit,
  output logic       q_bit
);

  logic next_bit;

  // 110/111 fall into default and hold
  always_comb begin
    next_bit = q_bit;
    case (mode)
      MODE_SHL:  next_bit = shl_bit;
      MODE_SHR:  next_bit = shr_bit;
      MODE_LOAD: next_bit = load_bit;
      MODE_ROL:  next_bit = rol_bit;
      MODE_ROR:  next_bit = ror_bit;
      default:   next_bit = q_bit;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_bit <= 1'b0;
    else     q_bit <= next_bit;
  end

endmodule

// File: rtl/pipo_universal_shift_reg.sv
// Parallel-in/parallel-out universal shift register with a
// saturating shift counter and a one-shot done pulse.
module pipo_universal_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 mode,
  input  logic [WIDTH-1:0]           din,
  input  logic                       sin_lsb,
  input  logic                       sin_msb,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_msb,
  output logic                       sout_lsb,
  output logic [$clog2(WIDTH+1)-1:0] count,
  output logic                       done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CMAX = CW'(WIDTH);
  localparam logic [CW-1:0] CPRE = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shl_in;
  logic [WIDTH-1:0] shr_in;
  logic [WIDTH-1:0] rol_in;
  logic [WIDTH-1:0] ror_in;

  assign shl_in = {q[WIDTH-2:0], sin_lsb};
  assign rol_in = {q[WIDTH-2:0], q[WIDTH-1]};
  assign shr_in = {sin_msb, q[WIDTH-1:1]};
  assign ror_in = {q[0], q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_bit_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .mode     (mode),
      .load_bit (din[i]),
      .shl_bit  (shl_in[i]),
      .shr_bit  (shr_in[i]),
      .rol_bit  (rol_in[i]),
      .ror_bit  (ror_in[i]),
      .q_bit    (q[i])
    );
  end

  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

  // done fires only on the WIDTH-1 -> WIDTH transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      done  <= 1'b0;
    end else if (mode == MODE_LOAD) begin
      count <= '0;
      done  <= 1'b0;
    end else if (is_shift(mode)) begin
      if (count != CMAX) count <= count + 1'b1;
      done <= (count == CPRE);
    end else begin
      done <= 1'b0;
    end
  end

endmodule
